// File: rtl/regfile_pkg.sv
// Shared register-file types and default datapath sizing.
package regfile_pkg;

    localparam int unsigned REGFILE_DATA_W = 32;
    localparam int unsigned REGFILE_NREGS  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_bypass_dump_if.sv
// Debug dump stream between the register file and the monitor/display logic.
interface regfile_bypass_dump_if import regfile_pkg::*; #(
    parameter int unsigned DATA_W = REGFILE_DATA_W,
    parameter int unsigned ADDR_W = 4
);
    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              dump_busy;

    modport master (
        input  dump_start, dump_ready,
        output dump_valid, dump_idx, dump_data, dump_last, dump_busy
    );

    modport slave (
        output dump_start, dump_ready,
        input  dump_valid, dump_idx, dump_data, dump_last, dump_busy
    );
endinterface

// File: rtl/regfile_dump_fsm.sv
// Sequential register dump engine: walks every index once, holding each
// captured word until the consumer accepts it.
module regfile_dump_fsm import regfile_pkg::*; #(
    parameter  int unsigned DATA_W = REGFILE_DATA_W,
    parameter  int unsigned NREGS  = REGFILE_NREGS,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] cap_data_c,
    output logic [ADDR_W-1:0] cap_addr_c,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              dump_busy
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    dump_state_t       state, state_d;
    logic              valid_d, last_d, busy_d;
    logic [ADDR_W-1:0] idx_d;
    logic [DATA_W-1:0] data_d;

    // Address of the word to capture at the next edge: index 0 on LOAD, else the successor.
    assign cap_addr_c = (state == LOAD) ? '0 : ADDR_W'(dump_idx + ADDR_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            dump_busy  <= 1'b0;
        end else begin
            state      <= state_d;
            dump_valid <= valid_d;
            dump_idx   <= idx_d;
            dump_data  <= data_d;
            dump_last  <= last_d;
            dump_busy  <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        valid_d = dump_valid;
        idx_d   = dump_idx;
        data_d  = dump_data;
        case (state)
            IDLE: begin
                if (dump_start) state_d = LOAD;
            end
            LOAD: begin
                idx_d   = '0;
                data_d  = cap_data_c;
                valid_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (dump_valid && dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = ADDR_W'(dump_idx + ADDR_W'(1));
                        data_d = cap_data_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        last_d = valid_d && (idx_d == LAST_IDX);
    end

endmodule

// File: rtl/regfile_bypass_dump.sv
// General-purpose register file: N bypassed read ports, two write ports
// (A has priority), PC-aliased top index and a handshaked debug dump.
module regfile_bypass_dump import regfile_pkg::*; #(
    parameter  int unsigned DATA_W = REGFILE_DATA_W,
    parameter  int unsigned NREGS  = REGFILE_NREGS,
    parameter  int unsigned NREAD  = 2,
    parameter  int unsigned PC_IDX = NREGS - 1,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREAD-1:0][ADDR_W-1:0]  ra,
    output logic [NREAD-1:0][DATA_W-1:0]  rd,
    input  logic [DATA_W-1:0]             pc_in,
    input  logic                          we_a,
    input  logic [ADDR_W-1:0]             wa_a,
    input  logic [DATA_W-1:0]             wd_a,
    input  logic                          we_b,
    input  logic [ADDR_W-1:0]             wa_b,
    input  logic [DATA_W-1:0]             wd_b,
    regfile_bypass_dump_if.master         dump
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs       [DEPTH];
    logic [ADDR_W-1:0] rport_addr [NREAD+1];
    logic [DATA_W-1:0] rport_data [NREAD+1];
    logic [ADDR_W-1:0] cap_addr_c;
    logic [DATA_W-1:0] cap_data_c;

    // Only real registers get flops; the PC alias and unused codes read as constant zero.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        if (g < NREGS && g != PC_IDX) begin : g_store
            logic [DATA_W-1:0] q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                              q <= '0;
                else if (we_a && wa_a == ADDR_W'(g))    q <= wd_a;
                else if (we_b && wa_b == ADDR_W'(g))    q <= wd_b;
            end
            assign regs[g] = q;
        end else begin : g_none
            assign regs[g] = '0;
        end
    end

    // The dump engine shares the read path as one extra port at the end.
    always_comb begin
        for (int p = 0; p < NREAD; p++) rport_addr[p] = ra[p];
        rport_addr[NREAD] = cap_addr_c;
    end

    always_comb begin
        for (int p = 0; p <= NREAD; p++) begin
            rport_data[p] = regs[rport_addr[p]];
            if (rport_addr[p] == ADDR_W'(PC_IDX))            rport_data[p] = pc_in;
            else if (we_a && wa_a == rport_addr[p])          rport_data[p] = wd_a;
            else if (we_b && wa_b == rport_addr[p])          rport_data[p] = wd_b;
        end
    end

    always_comb begin
        for (int p = 0; p < NREAD; p++) rd[p] = rport_data[p];
    end
    assign cap_data_c = rport_data[NREAD];

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_dump_fsm (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump.dump_start),
        .dump_ready (dump.dump_ready),
        .cap_data_c (cap_data_c),
        .cap_addr_c (cap_addr_c),
        .dump_valid (dump.dump_valid),
        .dump_idx   (dump.dump_idx),
        .dump_data  (dump.dump_data),
        .dump_last  (dump.dump_last),
        .dump_busy  (dump.dump_busy)
    );

endmodule
